// File: rtl/rv_writeback.sv
// rv_writeback -- register-file writeback stage.
//
// Retires ALU/shifter results one cycle after they are presented and aligns
// and extends load data from the data memory. If load data is late, the
// stage holds the upstream pipeline until it arrives.
//
// Optional feature: define RV_WB_BYPASS_EN to drive the forwarding outputs
// from the writeback registers. Without it, w_bypass_* are tied to zero.
//
// Ports
//   clk_i             core clock
//   rst_n_i           async active-low reset
//   x_valid_i         execute-stage result valid
//   x_rd_i            destination register index
//   x_rd_write_i      instruction writes rd
//   x_rd_source_i     0 ALU, 1 shifter, 2 load, 3 reserved (ALU)
//   x_alu_value_i     ALU result
//   x_shifter_value_i shifter result
//   x_fun_i           load funct3
//   x_dm_offset_i     load address bits [1:0]
//   dm_data_l_i       data-memory read word
//   dm_load_done_i    load data valid
//   w_stall_req_o     hold upstream pipeline
//   rf_write_o        register-file write strobe
//   rf_rd_o           register-file write index
//   rf_value_o        register-file write data
//   w_bypass_write_o  forwarding valid
//   w_bypass_rd_o     forwarding index
//   w_bypass_value_o  forwarding data
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | retire whatever execute presents; a late load leaves here
// LOAD_WAIT  | pipeline held, waiting for dm_load_done_i of pending load

module rv_writeback (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_valid_i,
  input  logic [4:0]  x_rd_i,
  input  logic        x_rd_write_i,
  input  logic [1:0]  x_rd_source_i,
  input  logic [31:0] x_alu_value_i,
  input  logic [31:0] x_shifter_value_i,
  input  logic [2:0]  x_fun_i,
  input  logic [1:0]  x_dm_offset_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  output logic        w_stall_req_o,
  output logic        rf_write_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_value_o,
  output logic        w_bypass_write_o,
  output logic [4:0]  w_bypass_rd_o,
  output logic [31:0] w_bypass_value_o
);

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] SRC_SHIFT = 2'd1;
  localparam logic [1:0] SRC_LOAD  = 2'd2;

  state_t      state_q, state_d;

  logic [4:0]  pend_rd_q;
  logic        pend_wr_q;
  logic [2:0]  pend_fun_q;
  logic [1:0]  pend_off_q;

  logic        stall;
  logic        capture;
  logic        retire;
  logic [4:0]  wr_rd;
  logic        wr_en;
  logic [31:0] wr_value;

  function automatic logic [31:0] load_align(input logic [31:0] word,
                                             input logic [2:0]  fun,
                                             input logic [1:0]  off);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] res;
    case (off)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    // Halfword lane comes from offset[1] alone; misaligned bit 0 is dropped.
    lane_h = off[1] ? word[31:16] : word[15:0];
    case (fun)
      3'b000:  res = {{24{lane_b[7]}}, lane_b};
      3'b001:  res = {{16{lane_h[15]}}, lane_h};
      3'b100:  res = {24'd0, lane_b};
      3'b101:  res = {16'd0, lane_h};
      default: res = word;
    endcase
    return res;
  endfunction

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    capture  = 1'b0;
    retire   = 1'b0;
    wr_rd    = x_rd_i;
    wr_en    = x_rd_write_i;
    wr_value = (x_rd_source_i == SRC_SHIFT) ? x_shifter_value_i : x_alu_value_i;
    case (state_q)
      IDLE: begin
        if (x_valid_i) begin
          if (x_rd_source_i == SRC_LOAD) begin
            if (dm_load_done_i) begin
              retire   = 1'b1;
              wr_value = load_align(dm_data_l_i, x_fun_i, x_dm_offset_i);
            end else begin
              stall   = 1'b1;
              capture = 1'b1;
              state_d = LOAD_WAIT;
            end
          end else begin
            retire = 1'b1;
          end
        end
      end
      LOAD_WAIT: begin
        stall = 1'b1;
        if (dm_load_done_i) begin
          // Release the pipeline in the cycle the data shows up.
          stall    = 1'b0;
          retire   = 1'b1;
          wr_rd    = pend_rd_q;
          wr_en    = pend_wr_q;
          wr_value = load_align(dm_data_l_i, pend_fun_q, pend_off_q);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall is combinational from the inputs, so gate it while in reset.
  assign w_stall_req_o = stall & rst_n_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      pend_rd_q  <= '0;
      pend_wr_q  <= 1'b0;
      pend_fun_q <= '0;
      pend_off_q <= '0;
      rf_write_o <= 1'b0;
      rf_rd_o    <= '0;
      rf_value_o <= '0;
    end else begin
      state_q    <= state_d;
      rf_write_o <= retire & wr_en & (wr_rd != 5'd0);
      if (capture) begin
        pend_rd_q  <= x_rd_i;
        pend_wr_q  <= x_rd_write_i;
        pend_fun_q <= x_fun_i;
        pend_off_q <= x_dm_offset_i;
      end
      if (retire) begin
        rf_rd_o    <= wr_rd;
        rf_value_o <= wr_value;
      end
    end
  end

`ifdef RV_WB_BYPASS_EN
  assign w_bypass_write_o = rf_write_o & (state_q != LOAD_WAIT);
  assign w_bypass_rd_o    = rf_rd_o;
  assign w_bypass_value_o = rf_value_o;
`else
  assign w_bypass_write_o = 1'b0;
  assign w_bypass_rd_o    = 5'd0;
  assign w_bypass_value_o = 32'd0;
`endif

endmodule

// File: tb/tb_rv_writeback.sv
module tb_rv_writeback;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        x_valid_i = 1'b0;
  logic [4:0]  x_rd_i = '0;
  logic        x_rd_write_i = 1'b0;
  logic [1:0]  x_rd_source_i = '0;
  logic [31:0] x_alu_value_i = '0;
  logic [31:0] x_shifter_value_i = '0;
  logic [2:0]  x_fun_i = '0;
  logic [1:0]  x_dm_offset_i = '0;
  logic [31:0] dm_data_l_i = '0;
  logic        dm_load_done_i = 1'b0;
  logic        w_stall_req_o;
  logic        rf_write_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_value_o;
  logic        w_bypass_write_o;
  logic [4:0]  w_bypass_rd_o;
  logic [31:0] w_bypass_value_o;

  int n_tests = 0;
  int n_fail  = 0;
  int stall_cycles;

`ifdef RV_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  rv_writeback dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .x_valid_i         (x_valid_i),
    .x_rd_i            (x_rd_i),
    .x_rd_write_i      (x_rd_write_i),
    .x_rd_source_i     (x_rd_source_i),
    .x_alu_value_i     (x_alu_value_i),
    .x_shifter_value_i (x_shifter_value_i),
    .x_fun_i           (x_fun_i),
    .x_dm_offset_i     (x_dm_offset_i),
    .dm_data_l_i       (dm_data_l_i),
    .dm_load_done_i    (dm_load_done_i),
    .w_stall_req_o     (w_stall_req_o),
    .rf_write_o        (rf_write_o),
    .rf_rd_o           (rf_rd_o),
    .rf_value_o        (rf_value_o),
    .w_bypass_write_o  (w_bypass_write_o),
    .w_bypass_rd_o     (w_bypass_rd_o),
    .w_bypass_value_o  (w_bypass_value_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic wr, input logic [4:0] rd,
                        input logic [31:0] val);
    chk({tag, "_write"}, {31'd0, rf_write_o}, {31'd0, wr});
    chk({tag, "_rd"}, {27'd0, rf_rd_o}, {27'd0, rd});
    chk({tag, "_value"}, rf_value_o, val);
    chk({tag, "_byp_write"}, {31'd0, w_bypass_write_o}, {31'd0, wr & BYP});
    chk({tag, "_byp_rd"}, {27'd0, w_bypass_rd_o}, BYP ? {27'd0, rd} : 32'd0);
    chk({tag, "_byp_value"}, w_bypass_value_o, BYP ? val : 32'd0);
  endtask

  task automatic present(input logic [1:0] src, input logic [4:0] rd, input logic rdw);
    x_valid_i     = 1'b1;
    x_rd_source_i = src;
    x_rd_i        = rd;
    x_rd_write_i  = rdw;
  endtask

  // Load vectors: funct3, offset, memory word, expected register value.
  logic [2:0]  ld_fun [8] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010, 3'b000, 3'b101, 3'b011};
  logic [1:0]  ld_off [8] = '{2'd3, 2'd3, 2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd2};
  logic [31:0] ld_exp [8] = '{32'hFFFFFF80, 32'h00000080, 32'h000080AA, 32'hFFFF80AA,
                              32'h80AABBCC, 32'hFFFFFFCC, 32'h0000BBCC, 32'h80AABBCC};

  initial begin
    // Reset with a late load on the inputs: stall must still read 0.
    #1 rst_n_i = 1'b0;
    present(2'd2, 5'd9, 1'b1);
    #2;
    chk("rst_stall", {31'd0, w_stall_req_o}, 32'd0);
    chk_wb("rst", 1'b0, 5'd0, 32'd0);
    x_valid_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    tick();

    // ALU retire and single-cycle pulse
    present(2'd0, 5'd5, 1'b1);
    x_alu_value_i = 32'h12345678;
    x_shifter_value_i = 32'h0BADF00D;
    tick();
    chk_wb("alu", 1'b1, 5'd5, 32'h12345678);
    x_valid_i = 1'b0;
    tick();
    chk_wb("alu_pulse", 1'b0, 5'd5, 32'h12345678);

    // Shifter, then x0 destination
    present(2'd1, 5'd7, 1'b1);
    x_shifter_value_i = 32'hFFFF0000;
    tick();
    chk_wb("shf", 1'b1, 5'd7, 32'hFFFF0000);
    present(2'd1, 5'd0, 1'b1);
    x_shifter_value_i = 32'h00C0FFEE;
    tick();
    chk_wb("shf_x0", 1'b0, 5'd0, 32'h00C0FFEE);

    // Reserved source behaves as ALU; rd_write=0 suppresses the strobe
    present(2'd3, 5'd4, 1'b1);
    x_alu_value_i = 32'h0000A5A5;
    tick();
    chk_wb("src3", 1'b1, 5'd4, 32'h0000A5A5);
    present(2'd0, 5'd3, 1'b0);
    x_alu_value_i = 32'h11112222;
    tick();
    chk_wb("nowr", 1'b0, 5'd3, 32'h11112222);
    present(2'd0, 5'd3, 1'b1);
    x_alu_value_i = 32'h33334444;
    tick();
    chk_wb("alu_rd3", 1'b1, 5'd3, 32'h33334444);

    // Loads completing in the same cycle
    dm_data_l_i = 32'h80AABBCC;
    dm_load_done_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      present(2'd2, 5'(20 + i), 1'b1);
      x_fun_i = ld_fun[i];
      x_dm_offset_i = ld_off[i];
      #1;
      chk($sformatf("ld%0d_stall", i), {31'd0, w_stall_req_o}, 32'd0);
      tick();
      chk_wb($sformatf("ld%0d", i), 1'b1, 5'(20 + i), ld_exp[i]);
    end

    // Done in IDLE with no load is ignored
    x_valid_i = 1'b0;
    dm_data_l_i = 32'h55555555;
    tick();
    chk_wb("idle_done", 1'b0, 5'd27, 32'h80AABBCC);

    // Late load: done arrives three cycles later, x_* toggling meanwhile
    dm_load_done_i = 1'b0;
    stall_cycles = 0;
    present(2'd2, 5'd9, 1'b1);
    x_fun_i = 3'b010;
    x_dm_offset_i = 2'd0;
    #1;
    if (w_stall_req_o) stall_cycles++;
    tick();
    present(2'd0, 5'd12, 1'b1);
    x_alu_value_i = 32'hAAAA0001;
    #1;
    if (w_stall_req_o) stall_cycles++;
    chk("lw_wait1_write", {31'd0, rf_write_o}, 32'd0);
    tick();
    x_valid_i = 1'b0;
    #1;
    if (w_stall_req_o) stall_cycles++;
    chk("lw_wait2_write", {31'd0, rf_write_o}, 32'd0);
    tick();
    present(2'd1, 5'd13, 1'b1);
    dm_load_done_i = 1'b1;
    dm_data_l_i = 32'hDEADBEEF;
    #1;
    if (w_stall_req_o) stall_cycles++;
    chk("lw_done_stall", {31'd0, w_stall_req_o}, 32'd0);
    chk("lw_stall_cycles", stall_cycles, 32'd3);
    tick();
    dm_load_done_i = 1'b0;
    x_valid_i = 1'b0;
    chk_wb("lw_late", 1'b1, 5'd9, 32'hDEADBEEF);
    tick();
    chk_wb("lw_after", 1'b0, 5'd9, 32'hDEADBEEF);

    // Reset during LOAD_WAIT discards the pending load
    present(2'd2, 5'd10, 1'b1);
    tick();
    x_valid_i = 1'b0;
    #1;
    chk("rw_stall_pre", {31'd0, w_stall_req_o}, 32'd1);
    rst_n_i = 1'b0;
    #1;
    chk("rw_stall_rst", {31'd0, w_stall_req_o}, 32'd0);
    chk_wb("rw_rst", 1'b0, 5'd0, 32'd0);
    tick();
    rst_n_i = 1'b1;
    tick();
    dm_load_done_i = 1'b1;
    dm_data_l_i = 32'h12121212;
    tick();
    dm_load_done_i = 1'b0;
    chk("rw_stall_post", {31'd0, w_stall_req_o}, 32'd0);
    chk_wb("rw_post", 1'b0, 5'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rv_writeback.md
RV_WRITEBACK -- requirements
Module: rv_writeback

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Ports, in order (name  direction  width  meaning):
- clk_i  in  1  core clock.
- rst_n_i  in  1  async active-low reset.
- x_valid_i  in  1  execute-stage result valid this cycle.
- x_rd_i  in  5  destination register index.
- x_rd_write_i  in  1  instruction writes rd.
- x_rd_source_i  in  2  result select: 0 ALU, 1 shifter, 2 load, 3 reserved (treated as ALU).
- x_alu_value_i  in  32  ALU result.
- x_shifter_value_i  in  32  shifter result, valid one cycle after shift issue.
- x_fun_i  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- x_dm_offset_i  in  2  load address bits [1:0].
- dm_data_l_i  in  32  data-memory read word.
- dm_load_done_i  in  1  load data valid this cycle.
- w_stall_req_o  out  1  holds upstream pipeline.
- rf_write_o  out  1  register-file write strobe.
- rf_rd_o  out  5  register-file write index.
- rf_value_o  out  32  register-file write data.
- w_bypass_write_o  out  1  forwarding valid.
- w_bypass_rd_o  out  5  forwarding index.
- w_bypass_value_o  out  32  forwarding data.

Function
REQ-003 SHALL implement FSM states IDLE and LOAD_WAIT.
REQ-004 In IDLE, x_valid_i=1 with source ALU/shifter SHALL register rf_write_o=x_rd_write_i AND (x_rd_i!=0), rf_rd_o=x_rd_i, rf_value_o=selected value at the next rising edge (latency 1).
REQ-005 In IDLE, x_valid_i=1 with source load and dm_load_done_i=1 in the same cycle SHALL complete the load as in REQ-004 with no stall.
REQ-006 In IDLE, x_valid_i=1 with source load and dm_load_done_i=0 SHALL capture rd, rd_write, fun, offset and enter LOAD_WAIT; w_stall_req_o SHALL be 1 combinationally in that cycle.
REQ-007 In LOAD_WAIT, w_stall_req_o SHALL be 1, x_* inputs SHALL be ignored, and rf_write_o SHALL be 0.
REQ-008 In LOAD_WAIT, dm_load_done_i=1 SHALL write the aligned data on the next edge, drop w_stall_req_o in that same cycle, and return to IDLE.
REQ-009 Load alignment: LB/LBU SHALL select byte lane offset[1:0]; LH/LHU SHALL select halfword lane offset[1], ignoring offset[0]; LW SHALL ignore offset.
REQ-010 LB/LH SHALL sign-extend to 32 bits; LBU/LHU SHALL zero-extend; undefined funct3 SHALL be treated as LW.
REQ-011 rf_write_o SHALL be a single-cycle pulse per retired instruction; with x_valid_i=0 in IDLE it SHALL be 0 on the next cycle.
REQ-012 Writes to x0 SHALL never assert rf_write_o, but rf_rd_o/rf_value_o SHALL still update.
REQ-013 dm_load_done_i in IDLE with no load presented SHALL be ignored.

Reset
REQ-014 Assertion of rst_n_i SHALL immediately force state IDLE, w_stall_req_o=0, rf_write_o=0, rf_rd_o=0, rf_value_o=0, and all bypass outputs to 0.
REQ-015 Reset during LOAD_WAIT SHALL discard the pending load; a dm_load_done_i arriving after reset release SHALL be ignored.

Configuration
REQ-016 Macro RV_WB_BYPASS_EN defined: w_bypass_* SHALL mirror rf_write_o/rf_rd_o/rf_value_o in the same cycle, and during LOAD_WAIT w_bypass_write_o SHALL be 0.
REQ-017 Macro RV_WB_BYPASS_EN undefined: w_bypass_write_o, w_bypass_rd_o, w_bypass_value_o SHALL be constant 0 and no bypass logic SHALL be synthesized.

Verification
REQ-018 ALU: x_valid_i=1, rd=5, source 0, alu=0x12345678 -> next cycle rf_write_o=1, rf_rd_o=5, rf_value_o=0x12345678, one-cycle pulse.
REQ-019 Shifter: source 1, rd=7, shifter=0xFFFF0000 -> next cycle rf_value_o=0xFFFF0000; rd=0 variant -> rf_write_o=0.
REQ-020 LB offset 3, dm_data_l_i=0x80AABBCC, done same cycle -> rf_value_o=0xFFFFFF80; LBU -> 0x00000080; LHU offset 2 -> 0x000080AA.
REQ-021 Load rd=9, done delayed 3 cycles with x_valid_i toggling -> w_stall_req_o=1 for exactly 3 cycles, single write rd=9, stalled inputs not written.
REQ-022 rst_n_i low during LOAD_WAIT, then done pulse after release -> no rf_write_o, w_stall_req_o=0, outputs zero.
REQ-023 With RV_WB_BYPASS_EN, ALU write rd=3 -> w_bypass_write_o=1, w_bypass_rd_o=3 same cycle as rf_write_o; without macro -> bypass outputs stay 0.
